// File: rtl/fp12_div.sv
// Sequential unsigned fixed-point divider (12-bit, INT_LEN integer bits), radix-2 restoring.
// Define FP12_DIV_ROUND_EN for round-to-nearest (ties up) via one extra guard-bit iteration.
module fp12_div #(
   parameter int INT_LEN = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] dividend,
   input  logic [11:0] divisor,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] quotient,
   output logic        overflow,
   output logic        div_by_zero
);

   localparam int FRAC = 12 - INT_LEN;
   localparam int ITER = 12 + FRAC;
`ifdef FP12_DIV_ROUND_EN
   localparam int GUARD = 1;
`else
   localparam int GUARD = 0;
`endif
   localparam int NW = ITER + GUARD;
   localparam int CW = $clog2(NW + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q;
   logic [12:0]     rem_q;
   logic [NW-1:0]   num_q;
   logic [NW-1:0]   quo_q;
   logic [11:0]     div_q;
   logic [CW-1:0]   cnt_q;
   logic            dz_q;
   logic            out_valid_q;
   logic [11:0]     quotient_q;
   logic            overflow_q;
   logic            div_by_zero_q;

   logic [12:0]     rem_shift;
   logic            rem_ge;
   logic [12:0]     rem_d;
   logic [NW-1:0]   quo_d;
   logic [ITER:0]   q_full;
   logic            ovf_d;
   logic [11:0]     res_d;

   // NOTE: combinational blocks assign every output first so no latch can be inferred.
   always_comb begin
      rem_shift = {rem_q[11:0], num_q[NW-1]};
      // A set top bit would mean R' already exceeds any 12-bit divisor.
      rem_ge    = rem_q[12] | (rem_shift >= {1'b0, div_q});
      rem_d     = rem_ge ? (rem_shift - {1'b0, div_q}) : rem_shift;
      quo_d     = {quo_q[NW-2:0], rem_ge};
`ifdef FP12_DIV_ROUND_EN
      q_full    = {1'b0, quo_q[NW-1:1]} + {{ITER{1'b0}}, quo_q[0]};
`else
      q_full    = {1'b0, quo_q};
`endif
      ovf_d     = |q_full[ITER:12];
      res_d     = ovf_d ? 12'hFFF : q_full[11:0];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rem_q         <= '0;
         num_q         <= '0;
         quo_q         <= '0;
         div_q         <= '0;
         cnt_q         <= '0;
         dz_q          <= 1'b0;
         out_valid_q   <= 1'b0;
         quotient_q    <= '0;
         overflow_q    <= 1'b0;
         div_by_zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  num_q   <= NW'(dividend) << (NW - 12);
                  div_q   <= divisor;
                  rem_q   <= '0;
                  quo_q   <= '0;
                  cnt_q   <= '0;
                  dz_q    <= (divisor == 12'd0);
                  state_q <= (divisor == 12'd0) ? DONE : CALC;
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               num_q <= num_q << 1;
               if (cnt_q == CW'(NW - 1)) begin
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               // First DONE cycle publishes the result; it is then held until consumed.
               if (!out_valid_q) begin
                  out_valid_q   <= 1'b1;
                  quotient_q    <= dz_q ? 12'hFFF : res_d;
                  overflow_q    <= dz_q ? 1'b0 : ovf_d;
                  div_by_zero_q <= dz_q;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign overflow    = overflow_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_fp12_div.sv
// Self-checking bench for fp12_div: directed vector table, handshake corner cases,
// and randomized traffic scored against an arithmetic reference model.
module tb_fp12_div;

   localparam int FRAC = 4;
   localparam int ITER = 16;
`ifdef FP12_DIV_ROUND_EN
   localparam int ROUND = 1;
`else
   localparam int ROUND = 0;
`endif
   localparam int LAT = ITER + 1 + ROUND;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] dividend = '0;
   logic [11:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] quotient;
   logic        overflow;
   logic        div_by_zero;

   fp12_div dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [11:0] q;
      logic        ov;
      logic        dz;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: quotient = floor(a * 2^FRAC / b), or nearest (ties up) when rounding.
   function automatic vec_t ref_div(input logic [11:0] a, input logic [11:0] b);
      vec_t r;
      longint unsigned t;
      r.a = a;
      r.b = b;
      if (b == 12'd0) begin
         r.q  = 12'hFFF;
         r.ov = 1'b0;
         r.dz = 1'b1;
      end else begin
         t = (longint'(a) * (longint'(1) << (FRAC + ROUND))) / longint'(b);
         if (ROUND == 1) t = (t + 1) / 2;
         r.ov = (t > 4095);
         r.q  = r.ov ? 12'hFFF : 12'(t);
         r.dz = 1'b0;
      end
      return r;
   endfunction

   // Called at #1 after a rising edge with the divider expected idle.
   task automatic do_op(input vec_t v, input string tag);
      int lat;
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         @(posedge clk); #1; w++;
      end
      check({tag, " in_ready before op"}, in_ready, 1);
      dividend = v.a;
      divisor  = v.b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, " latency"}, lat, v.dz ? 1 : LAT);
      check({tag, " quotient"}, quotient, v.q);
      check({tag, " overflow"}, overflow, v.ov);
      check({tag, " div_by_zero"}, div_by_zero, v.dz);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " out_valid after consume"}, out_valid, 0);
      check({tag, " in_ready after consume"}, in_ready, 1);
   endtask

   vec_t vecs[14];
   vec_t sb[$];
   vec_t e;

   initial begin
      int lat;
      int accepted;
      int consumed;
      int cyc;
      logic spurious;

      vecs[0]  = '{12'h038, 12'h020, 12'h01C, 1'b0, 1'b0};
      vecs[1]  = '{12'h020, 12'h030, (ROUND == 1) ? 12'h00B : 12'h00A, 1'b0, 1'b0};
      vecs[2]  = '{12'hFFF, 12'h001, 12'hFFF, 1'b1, 1'b0};
      vecs[3]  = '{12'h123, 12'h000, 12'hFFF, 1'b0, 1'b1};
      vecs[4]  = '{12'h010, 12'h010, 12'h010, 1'b0, 1'b0};
      vecs[5]  = '{12'h001, 12'hFFF, 12'h000, 1'b0, 1'b0};
      vecs[6]  = '{12'hFFF, 12'hFFF, 12'h010, 1'b0, 1'b0};
      vecs[7]  = '{12'h100, 12'h010, 12'h100, 1'b0, 1'b0};
      vecs[8]  = '{12'h800, 12'h008, 12'hFFF, 1'b1, 1'b0};
      vecs[9]  = '{12'h7FF, 12'h008, 12'hFFE, 1'b0, 1'b0};
      vecs[10] = '{12'hFFF, 12'h010, 12'hFFF, 1'b0, 1'b0};
      vecs[11] = '{12'h001, 12'h020, (ROUND == 1) ? 12'h001 : 12'h000, 1'b0, 1'b0};
      vecs[12] = '{12'h000, 12'h005, 12'h000, 1'b0, 1'b0};
      vecs[13] = '{12'hFFF, 12'h00F, 12'hFFF, 1'b1, 1'b0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset quotient", quotient, 0);
      check("reset overflow", overflow, 0);
      check("reset div_by_zero", div_by_zero, 0);

      for (int i = 0; i < 14; i++) do_op(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: result held, new operands ignored while waiting.
      dividend = 12'h038;
      divisor  = 12'h020;
      in_valid = 1'b1;
      @(posedge clk); #1;
      dividend = 12'h123;
      divisor  = 12'h000;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      check("bp latency", lat, LAT);
      for (int i = 0; i < 10; i++) begin
         check("bp out_valid", out_valid, 1);
         check("bp quotient", quotient, 12'h01C);
         check("bp overflow", overflow, 0);
         check("bp div_by_zero", div_by_zero, 0);
         check("bp in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("bp in_ready after consume", in_ready, 1);
      check("bp out_valid after consume", out_valid, 0);
      check("bp quotient retained", quotient, 12'h01C);
      spurious = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid || !in_ready) spurious = 1'b1;
      end
      check("bp ignored operand produced no result", spurious, 0);

      // Reset during CALC discards the division.
      dividend = 12'hFFF;
      divisor  = 12'h001;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst mid-calc in_ready", in_ready, 1);
      check("rst mid-calc out_valid", out_valid, 0);
      check("rst mid-calc quotient", quotient, 0);
      check("rst mid-calc overflow", overflow, 0);
      do_op('{12'h010, 12'h010, 12'h010, 1'b0, 1'b0}, "after rst");

      // Random traffic with random backpressure against the reference model.
      accepted = 0;
      consumed = 0;
      cyc      = 0;
      while ((accepted < 1000 || sb.size() != 0) && cyc < 60000) begin
         @(negedge clk);
         in_valid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
         dividend = 12'($urandom);
         case ($urandom_range(0, 7))
            0:       divisor = 12'h000;
            1:       divisor = 12'($urandom_range(1, 15));
            default: divisor = 12'($urandom);
         endcase
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (in_valid && in_ready) begin
            sb.push_back(ref_div(dividend, divisor));
            accepted++;
         end
         if (out_valid && out_ready) begin
            consumed++;
            if (sb.size() == 0) begin
               check("rnd unexpected result", 1, 0);
            end else begin
               e = sb.pop_front();
               check($sformatf("rnd %03h/%03h quotient", e.a, e.b), quotient, e.q);
               check($sformatf("rnd %03h/%03h overflow", e.a, e.b), overflow, e.ov);
               check($sformatf("rnd %03h/%03h div_by_zero", e.a, e.b), div_by_zero, e.dz);
            end
         end
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("rnd cycle budget exceeded", (cyc >= 60000), 0);
      check("rnd accepted count", accepted, 1000);
      check("rnd consumed count", consumed, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
